button_repeat_events: RTL and testbench
=======================================

Name: button_repeat_events

Overview:
- Sits between the three debounce filters and the tally score register.
- Converts debounced switch levels into single-cycle command pulses: increment, decrement, clear.
- Increment and decrement auto-repeat while held: first pulse on press, second after an initial delay, then one at a fixed rate. Clear fires once per press.
- Replaces the free-running rate-gating counter in the score logic; the score register consumes one pulse per step.

Parameters:
- CLKS_INITIAL, 12500000, cycles from first pulse to second pulse while held (0.5 s at 25 MHz); legal range 2..2^25-1.
- CLKS_REPEAT, 2500000, cycles between subsequent repeat pulses (0.1 s at 25 MHz); legal range 2..2^25-1.

Ports:
- i_Clk  input  1  system clock
- i_Reset  input  1  synchronous reset, active-high
- i_Inc_Level  input  1  debounced switch 1 level
- i_Dec_Level  input  1  debounced switch 2 level
- i_Clr_Level  input  1  debounced switch 3 level
- o_Inc  output  1  one-cycle increment pulse
- o_Dec  output  1  one-cycle decrement pulse
- o_Clr  output  1  one-cycle clear pulse
- o_Busy  output  1  high while any button owns the block (state != IDLE)

Behaviour:
- All outputs are registered. o_Inc, o_Dec, o_Clr and o_Busy reset to 0. The FSM resets to IDLE, the owner to NONE and the counter to 0.
- At most one of o_Inc/o_Dec/o_Clr is high in any cycle.
- Ownership:
  - In IDLE, the first sampled-high input becomes owner.
  - Same-cycle ties resolve Inc > Dec > Clr.
  - Non-owner inputs are ignored until the owner is released and the FSM returns to IDLE.
- States: IDLE, ARM_WAIT, HOLD_INITIAL, HOLD_REPEAT, HOLD_ONCE.
- Reset → ARM_WAIT when any input is high at the reset cycle, else IDLE. In ARM_WAIT no pulses are emitted; go to IDLE once all inputs are sampled low. A button held through reset never produces a pulse.
- IDLE → press of Inc or Dec at edge k:
  - Output pulse high for the cycle after edge k (latency 1 cycle).
  - Counter loaded with 1; go to HOLD_INITIAL.
- IDLE → press of Clr:
  - o_Clr pulse with latency 1; go to HOLD_ONCE.
- HOLD_INITIAL:
  - Counter increments each cycle.
  - When it reaches CLKS_INITIAL with the owner still high: pulse, counter = 1, go to HOLD_REPEAT.
  - Second pulse is exactly CLKS_INITIAL cycles after the first.
- HOLD_REPEAT: same as HOLD_INITIAL against CLKS_REPEAT. A pulse is emitted each CLKS_REPEAT cycles and the state is kept.
- HOLD_ONCE: no pulses; wait for release.
- Release (owner sampled low) in any HOLD state → IDLE next edge, counter cleared. If release coincides with counter expiry, release wins and no pulse is emitted.
- A re-press in the cycle after returning to IDLE is a fresh press.
- Counter is 25 bits and saturates. No wrap is possible within the legal parameter range.
- Reset asserted mid-hold takes priority over everything: outputs 0 next edge, then the ARM_WAIT rule applies.
- Levels are assumed synchronous (already debounced in the i_Clk domain). No extra synchronizer.

Decomposition:
- Shared package/header:
  - state encodings (3-bit localparams IDLE=0, ARM_WAIT=1, HOLD_INITIAL=2, HOLD_REPEAT=3, HOLD_ONCE=4);
  - owner encodings (NONE, INC, DEC, CLR);
  - COUNTER_WIDTH=25.
- One natural sub-module: repeat_timer. It holds the loadable saturating counter with a compare-against-limit output and takes start/clear/limit-select inputs. The FSM and arbitration stay in the top.

Test Plan (CLKS_INITIAL=10, CLKS_REPEAT=4 for all benches):
- Inc held 30 cycles from edge 0 → o_Inc high after edges 0, 10, 14, 18, 22, 26 (6 pulses), none after release; o_Dec/o_Clr stay 0.
- Clr held 50 cycles → exactly one o_Clr pulse after edge 0; o_Busy high until the cycle after release.
- Inc and Dec rise on the same edge → only o_Inc pulses. Releasing Inc while Dec stays high → Dec pulses the cycle after the FSM is back in IDLE (2 edges after Inc is sampled low).
- Inc released on the exact edge its counter reaches 10 → no second pulse; o_Busy falls next cycle.
- Dec held, i_Reset asserted for 1 cycle at edge 12, Dec kept high → no pulses after reset. Dec low for 1 cycle then high → new o_Dec pulse 1 cycle later.
- Dec held 5 cycles, released 1 cycle, held again → two o_Dec pulses spaced 6 cycles; no repeat before CLKS_INITIAL is reached on the second press.

Source files
------------

// File: rtl/button_repeat_events_pkg.sv
// Shared encodings for the button repeat event generator.
package button_repeat_events_pkg;

  localparam int unsigned COUNTER_WIDTH = 25;

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_ARM_WAIT     = 3'd1,
    S_HOLD_INITIAL = 3'd2,
    S_HOLD_REPEAT  = 3'd3,
    S_HOLD_ONCE    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INC  = 2'd1,
    OWN_DEC  = 2'd2,
    OWN_CLR  = 2'd3
  } owner_e;

  // Level of the button that currently owns the block.
  function automatic logic owner_level(owner_e owner, logic inc, logic dec, logic clr);
    logic lvl;
    case (owner)
      OWN_INC: lvl = inc;
      OWN_DEC: lvl = dec;
      OWN_CLR: lvl = clr;
      default: lvl = 1'b0;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/button_repeat_events_repeat_timer.sv
// Loadable saturating hold counter with a compare against the selected limit.
module repeat_timer
  import button_repeat_events_pkg::*;
#(
  parameter int unsigned CLKS_INITIAL = 12500000,
  parameter int unsigned CLKS_REPEAT  = 2500000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_start,
  input  logic i_clear,
  input  logic i_run,
  input  logic i_limit_sel,
  output logic o_expired
);

  localparam logic [COUNTER_WIDTH-1:0] LIMIT_INITIAL = COUNTER_WIDTH'(CLKS_INITIAL);
  localparam logic [COUNTER_WIDTH-1:0] LIMIT_REPEAT  = COUNTER_WIDTH'(CLKS_REPEAT);
  localparam logic [COUNTER_WIDTH-1:0] COUNT_MAX     = {COUNTER_WIDTH{1'b1}};

  logic [COUNTER_WIDTH-1:0] count_q;
  logic [COUNTER_WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = {COUNTER_WIDTH{1'b0}};
    end else if (i_start) begin
      count_d = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
    end else if (i_run && (count_q != COUNT_MAX)) begin
      count_d = count_q + {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_q <= {COUNTER_WIDTH{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign o_expired = (count_q == (i_limit_sel ? LIMIT_REPEAT : LIMIT_INITIAL));

endmodule

// File: rtl/button_repeat_events.sv
// Turns debounced button levels into single-cycle inc/dec/clear pulses with
// auto-repeat on inc/dec; the first pressed button owns the block until released.
module button_repeat_events
  import button_repeat_events_pkg::*;
#(
  parameter int unsigned CLKS_INITIAL = 12500000,
  parameter int unsigned CLKS_REPEAT  = 2500000
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Inc_Level,
  input  logic i_Dec_Level,
  input  logic i_Clr_Level,
  output logic o_Inc,
  output logic o_Dec,
  output logic o_Clr,
  output logic o_Busy
);

  state_e state_q, state_d;
  owner_e owner_q, owner_d;
  logic   inc_q, inc_d;
  logic   dec_q, dec_d;
  logic   clr_q, clr_d;
  logic   busy_q;

  logic   tmr_start, tmr_clear, tmr_run, tmr_sel, tmr_expired;
  logic   any_level, own_level;

  assign any_level = i_Inc_Level | i_Dec_Level | i_Clr_Level;
  assign own_level = owner_level(owner_q, i_Inc_Level, i_Dec_Level, i_Clr_Level);

  repeat_timer #(
    .CLKS_INITIAL (CLKS_INITIAL),
    .CLKS_REPEAT  (CLKS_REPEAT)
  ) u_timer (
    .i_clk       (i_Clk),
    .i_reset     (i_Reset),
    .i_start     (tmr_start),
    .i_clear     (tmr_clear),
    .i_run       (tmr_run),
    .i_limit_sel (tmr_sel),
    .o_expired   (tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    inc_d     = 1'b0;
    dec_d     = 1'b0;
    clr_d     = 1'b0;
    tmr_start = 1'b0;
    tmr_clear = 1'b0;
    tmr_run   = 1'b0;
    tmr_sel   = (state_q == S_HOLD_REPEAT);
    case (state_q)
      S_IDLE: begin
        if (i_Inc_Level) begin
          owner_d   = OWN_INC;
          inc_d     = 1'b1;
          tmr_start = 1'b1;
          state_d   = S_HOLD_INITIAL;
        end else if (i_Dec_Level) begin
          owner_d   = OWN_DEC;
          dec_d     = 1'b1;
          tmr_start = 1'b1;
          state_d   = S_HOLD_INITIAL;
        end else if (i_Clr_Level) begin
          owner_d   = OWN_CLR;
          clr_d     = 1'b1;
          state_d   = S_HOLD_ONCE;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_ARM_WAIT: begin
        if (!any_level) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_ARM_WAIT;
        end
      end
      S_HOLD_INITIAL, S_HOLD_REPEAT: begin
        // Release takes precedence over a coincident expiry.
        if (!own_level) begin
          owner_d   = OWN_NONE;
          tmr_clear = 1'b1;
          state_d   = S_IDLE;
        end else if (tmr_expired) begin
          inc_d     = (owner_q == OWN_INC);
          dec_d     = (owner_q == OWN_DEC);
          tmr_start = 1'b1;
          state_d   = S_HOLD_REPEAT;
        end else begin
          tmr_run   = 1'b1;
        end
      end
      S_HOLD_ONCE: begin
        if (!own_level) begin
          owner_d   = OWN_NONE;
          tmr_clear = 1'b1;
          state_d   = S_IDLE;
        end else begin
          state_d   = S_HOLD_ONCE;
        end
      end
      default: begin
        owner_d   = OWN_NONE;
        tmr_clear = 1'b1;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q <= any_level ? S_ARM_WAIT : S_IDLE;
      owner_q <= OWN_NONE;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      clr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
      clr_q   <= clr_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign o_Inc  = inc_q;
  assign o_Dec  = dec_q;
  assign o_Clr  = clr_q;
  assign o_Busy = busy_q;

endmodule

// File: tb/tb_button_repeat_events.sv
// Self-checking bench for button_repeat_events: directed scenarios plus
// random levels, all checked against an elapsed-time reference model.
module tb_button_repeat_events;

  localparam int INIT = 10;
  localparam int REP  = 4;

  logic i_Clk = 1'b0;
  logic i_Reset = 1'b1;
  logic i_Inc_Level = 1'b0;
  logic i_Dec_Level = 1'b0;
  logic i_Clr_Level = 1'b0;
  logic o_Inc, o_Dec, o_Clr, o_Busy;

  int n_checks = 0;
  int n_fail = 0;

  button_repeat_events #(.CLKS_INITIAL(INIT), .CLKS_REPEAT(REP)) dut (
    .i_Clk       (i_Clk),
    .i_Reset     (i_Reset),
    .i_Inc_Level (i_Inc_Level),
    .i_Dec_Level (i_Dec_Level),
    .i_Clr_Level (i_Clr_Level),
    .o_Inc       (o_Inc),
    .o_Dec       (o_Dec),
    .o_Clr       (o_Clr),
    .o_Busy      (o_Busy)
  );

  always #5 i_Clk = ~i_Clk;

  // Model: owner 0=none 1=inc 2=dec 3=clr; pulses derive from elapsed edges since press.
  typedef struct {
    int owner;
    bit arm;
    int t;
    int t0;
    logic [3:0] exp;  // {inc, dec, clr, busy}
  } mstate_t;

  mstate_t m = '{owner: 0, arm: 1'b0, t: 0, t0: 0, exp: 4'b0000};

  function automatic mstate_t model_step(mstate_t s, bit inc, bit dec, bit clr, bit rst);
    mstate_t n = s;
    int d;
    bit lvl;
    n.t = s.t + 1;
    n.exp = 4'b0000;
    if (rst) begin
      n.arm = inc | dec | clr;
      n.owner = 0;
      return n;
    end
    if (s.arm) begin
      if (!(inc | dec | clr)) n.arm = 1'b0;
    end else if (s.owner == 0) begin
      n.t0 = s.t;
      if (inc)      begin n.owner = 1; n.exp[3] = 1'b1; end
      else if (dec) begin n.owner = 2; n.exp[2] = 1'b1; end
      else if (clr) begin n.owner = 3; n.exp[1] = 1'b1; end
    end else begin
      lvl = (s.owner == 1) ? inc : (s.owner == 2) ? dec : clr;
      if (!lvl) begin
        n.owner = 0;
      end else if (s.owner != 3) begin
        d = s.t - s.t0;
        if (d >= INIT && ((d - INIT) % REP) == 0) begin
          if (s.owner == 1) n.exp[3] = 1'b1;
          else n.exp[2] = 1'b1;
        end
      end
    end
    n.exp[0] = (n.owner != 0) || n.arm;
    return n;
  endfunction

  always @(posedge i_Clk) m <= model_step(m, i_Inc_Level, i_Dec_Level, i_Clr_Level, i_Reset);

  // Drive levels for the next edge and wait until after it.
  task automatic cyc(input bit inc, input bit dec, input bit clr, input bit rst);
    i_Inc_Level = inc;
    i_Dec_Level = dec;
    i_Clr_Level = clr;
    i_Reset = rst;
    @(negedge i_Clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if ({o_Inc, o_Dec, o_Clr, o_Busy} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_state cycle %0d: got %b expected 0000", i, {o_Inc, o_Dec, o_Clr, o_Busy});
      end
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_inc_hold();
    int pos[$];
    int want[6] = '{0, 10, 14, 18, 22, 26};
    for (int i = 0; i < 36; i++) begin
      cyc(i < 30, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if ({o_Inc, o_Dec, o_Clr, o_Busy} !== m.exp) begin
        n_fail++;
        $display("FAIL inc_hold edge %0d: got %b expected %b", i, {o_Inc, o_Dec, o_Clr, o_Busy}, m.exp);
      end
      if (o_Inc === 1'b1) pos.push_back(i);
    end
    n_checks++;
    if (pos.size() != 6) begin
      n_fail++;
      $display("FAIL inc_hold_count: got %0d pulses expected 6", pos.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        n_checks++;
        if (pos[k] != want[k]) begin
          n_fail++;
          $display("FAIL inc_hold_pos %0d: got edge %0d expected %0d", k, pos[k], want[k]);
        end
      end
    end
  endtask

  task automatic test_clr_hold();
    int cnt = 0;
    for (int i = 0; i < 54; i++) begin
      cyc(1'b0, 1'b0, i < 50, 1'b0);
      n_checks++;
      if ({o_Inc, o_Dec, o_Clr, o_Busy} !== m.exp) begin
        n_fail++;
        $display("FAIL clr_hold edge %0d: got %b expected %b", i, {o_Inc, o_Dec, o_Clr, o_Busy}, m.exp);
      end
      if (o_Clr === 1'b1) cnt++;
      if (i == 49 || i == 50) begin
        n_checks++;
        if (o_Busy !== (i == 49)) begin
          n_fail++;
          $display("FAIL clr_busy edge %0d: got %b expected %b", i, o_Busy, (i == 49));
        end
      end
    end
    n_checks++;
    if (cnt != 1) begin
      n_fail++;
      $display("FAIL clr_once: got %0d pulses expected 1", cnt);
    end
  endtask

  task automatic test_tie();
    int inc_cnt = 0;
    int first_dec = -1;
    for (int i = 0; i < 12; i++) begin
      cyc(i < 5, i < 9, 1'b0, 1'b0);
      n_checks++;
      if ({o_Inc, o_Dec, o_Clr, o_Busy} !== m.exp) begin
        n_fail++;
        $display("FAIL tie edge %0d: got %b expected %b", i, {o_Inc, o_Dec, o_Clr, o_Busy}, m.exp);
      end
      if (o_Inc === 1'b1) inc_cnt++;
      if (o_Dec === 1'b1 && first_dec < 0) first_dec = i;
    end
    n_checks++;
    if (inc_cnt != 1 || first_dec != 6) begin
      n_fail++;
      $display("FAIL tie_priority: got inc=%0d first_dec=%0d expected inc=1 first_dec=6", inc_cnt, first_dec);
    end
  endtask

  task automatic test_release_at_expiry();
    int cnt = 0;
    for (int i = 0; i < 14; i++) begin
      cyc(i < 10, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if ({o_Inc, o_Dec, o_Clr, o_Busy} !== m.exp) begin
        n_fail++;
        $display("FAIL rel_expiry edge %0d: got %b expected %b", i, {o_Inc, o_Dec, o_Clr, o_Busy}, m.exp);
      end
      if (o_Inc === 1'b1) cnt++;
      if (i == 10) begin
        n_checks++;
        if (o_Busy !== 1'b0) begin
          n_fail++;
          $display("FAIL rel_expiry_busy: got %b expected 0", o_Busy);
        end
      end
    end
    n_checks++;
    if (cnt != 1) begin
      n_fail++;
      $display("FAIL rel_expiry_count: got %0d pulses expected 1", cnt);
    end
  endtask

  task automatic test_reset_mid_hold();
    int late = 0;
    int first_new = -1;
    for (int i = 0; i < 26; i++) begin
      cyc(1'b0, (i != 21), 1'b0, (i == 12));
      n_checks++;
      if ({o_Inc, o_Dec, o_Clr, o_Busy} !== m.exp) begin
        n_fail++;
        $display("FAIL rst_mid edge %0d: got %b expected %b", i, {o_Inc, o_Dec, o_Clr, o_Busy}, m.exp);
      end
      if (o_Dec === 1'b1 && i >= 12 && i <= 21) late++;
      if (o_Dec === 1'b1 && i > 21 && first_new < 0) first_new = i;
    end
    n_checks++;
    if (late != 0 || first_new != 22) begin
      n_fail++;
      $display("FAIL rst_mid_pulses: got held=%0d new_at=%0d expected held=0 new_at=22", late, first_new);
    end
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int pos[$];
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, (i != 5), 1'b0, 1'b0);
      n_checks++;
      if ({o_Inc, o_Dec, o_Clr, o_Busy} !== m.exp) begin
        n_fail++;
        $display("FAIL repress edge %0d: got %b expected %b", i, {o_Inc, o_Dec, o_Clr, o_Busy}, m.exp);
      end
      if (o_Dec === 1'b1) pos.push_back(i);
    end
    n_checks++;
    if (pos.size() != 3 || pos[0] != 0 || pos[1] != 6 || pos[2] != 16) begin
      n_fail++;
      $display("FAIL repress_pos: got %0d pulses %p expected edges 0,6,16", pos.size(), pos);
    end
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    bit a = 0, b = 0, c = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 99) < 6) a = ~a;
      if ($urandom_range(0, 99) < 6) b = ~b;
      if ($urandom_range(0, 99) < 6) c = ~c;
      cyc(a, b, c, ($urandom_range(0, 199) == 0));
      n_checks++;
      if ({o_Inc, o_Dec, o_Clr, o_Busy} !== m.exp) begin
        n_fail++;
        $display("FAIL random cycle %0d: got %b expected %b", i, {o_Inc, o_Dec, o_Clr, o_Busy}, m.exp);
      end
      n_checks++;
      if ((o_Inc + o_Dec + o_Clr) > 1) begin
        n_fail++;
        $display("FAIL onehot cycle %0d: got %b expected at most one pulse", i, {o_Inc, o_Dec, o_Clr});
      end
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    @(negedge i_Clk);
    test_reset();
    test_inc_hold();
    test_clr_hold();
    test_tie();
    test_release_at_expiry();
    test_reset_mid_hold();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
